instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction-fetch consumer for the program-counter register: accepts fetch addresses from the PC register, issues one read at a time to instruction memory, and buffers the returned words with their PCs in a small FIFO for the decode stage. It back-pressures the PC register with a ready signal and discards buffered and in-flight fetches on a control-flow redirect (flush).

## Interface
Parameters:
- DATA_WIDTH, 32, width of PC, address and instruction word
- DEPTH, 4, FIFO entries (power of two, ≥2)

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  reset, asynchronous and active-low
- pc_i  input  DATA_WIDTH  fetch address from PC register
- pc_valid_i  input  1  pc_i holds an address to fetch
- pc_ready_o  output  1  address accepted this cycle when high with pc_valid_i
- flush_i  input  1  redirect: drop FIFO contents and any in-flight response
- mem_req_o  output  1  one-cycle read request pulse
- mem_addr_o  output  DATA_WIDTH  word-aligned read address, held until response
- mem_rvalid_i  input  1  read data valid
- mem_rdata_i  input  DATA_WIDTH  read data
- instr_valid_o  output  1  FIFO head valid
- instr_ready_i  input  1  decode consumes head
- instr_o  output  DATA_WIDTH  head instruction
- instr_pc_o  output  DATA_WIDTH  head PC
- instr_err_o  output  1  head is a misaligned-fetch marker (only with FETCH_MISALIGN_CHECK_EN)

## Operation
- FSM states: IDLE, WAIT, DROP. At most one outstanding memory read.
- pc_ready_o = (state==IDLE) && (count<DEPTH) && !flush_i; combinational.
- IDLE, accept: latch mem_addr_o={pc_i[DATA_WIDTH-1:2],2'b00}, latch pc_i, mem_req_o=1 next cycle, go WAIT.
- WAIT, mem_rvalid_i && !flush_i: push {latched pc, mem_rdata_i}, go IDLE.
- WAIT, flush_i (with or without mem_rvalid_i): if rvalid same cycle go IDLE, else DROP; nothing pushed.
- DROP: mem_rvalid_i -> IDLE, data discarded; flush_i in DROP keeps DROP.
- flush_i in IDLE: stay IDLE, no accept that cycle.
- FIFO: instr_valid_o = (count!=0); outputs driven from head entry. Pop on instr_valid_o && instr_ready_i. Push and pop same cycle: count unchanged, both pointers advance. Pointers wrap modulo DEPTH.
- flush_i: count, read and write pointers cleared next edge; pop and push ignored that cycle.
- Push never occurs when full (accept requires count<DEPTH, only one outstanding).
- Reset mid-operation: FSM to IDLE, FIFO emptied, pending response ignored; memory must not return data for a request issued before reset.

## Timing
- Reset values: state IDLE, count 0, pointers 0, mem_req_o 0, mem_addr_o 0, instr_valid_o 0, instr_o 0, instr_pc_o 0, instr_err_o 0; pc_ready_o 1 once rst deasserted.
- mem_rvalid_i arrives ≥1 cycle after mem_req_o; rvalid in the mem_req_o cycle is ignored.
- Accept at cycle T: mem_req_o at T+1; rvalid at T+1+L (L≥1); instr_valid_o at T+2+L.
- Best-case throughput: one instruction per 3 cycles (next accept in cycle after rvalid).
- Flush at cycle F: instr_valid_o low from F+1; pc_ready_o high at F+1 if not DROP.

## Configuration
- FETCH_MISALIGN_CHECK_EN defined: accepted pc_i with pc_i[1:0]!=0 issues no memory request; pushes entry {pc_i, instr=0, err=1} next cycle, stays IDLE; instr_err_o driven from head err bit.
- Undefined: pc_i[1:0] ignored, every accept issues a read; instr_err_o port absent, no err bit stored.

## Test plan
- Reset then pc_i=0x00000000 valid, memory L=1 returns 0x00500093 -> mem_req_o at T+1, mem_addr_o=0, instr_valid_o at T+3 with instr_o=0x00500093, instr_pc_o=0.
- instr_ready_i held 0, fetch PCs 0x0,0x4,0x8,0xC -> count=4, pc_ready_o=0; pop one -> pc_ready_o=1 next cycle; entries exit in order.
- flush_i in WAIT, rvalid 3 cycles later with 0xDEADBEEF -> FSM DROP then IDLE, no push, instr_valid_o stays 0.
- flush_i same cycle as mem_rvalid_i with 2 entries buffered -> FIFO empty next cycle, state IDLE, data dropped.
- Push and pop same cycle with count=2 -> count remains 2, head advances; pointer wrap after 5 pushes verified.
- FETCH_MISALIGN_CHECK_EN defined, pc_i=0x00000102 -> no mem_req_o, entry instr_o=0, instr_pc_o=0x102, instr_err_o=1; undefined -> mem_addr_o=0x100.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: takes PCs from the PC register, issues one memory read at a
// time and queues {pc, instr} for decode. Optional: FETCH_MISALIGN_CHECK_EN.
module instr_fetch_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] pc_i,
    input  logic                  pc_valid_i,
    output logic                  pc_ready_o,
    input  logic                  flush_i,
    output logic                  mem_req_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [DATA_WIDTH-1:0] instr_pc_o
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic                  instr_err_o
`endif
);

    // state    | meaning
    // ST_IDLE  | no read outstanding, may accept a PC
    // ST_WAIT  | read outstanding, response will be queued
    // ST_DROP  | read outstanding after a flush, response discarded
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    localparam int              PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W+1)'(DEPTH);

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   pc_q;
    logic [PTR_W-1:0]        rd_ptr, wr_ptr;
    logic [PTR_W:0]          count_q;

    logic [DATA_WIDTH-1:0]   fifo_data [DEPTH];
    logic [DATA_WIDTH-1:0]   fifo_pc   [DEPTH];
`ifdef FETCH_MISALIGN_CHECK_EN
    logic                    fifo_err  [DEPTH];
`endif

    logic                    accept;
    logic                    misalign;
    logic                    rvalid_eff;
    logic                    push_fetch;
    logic                    push_err;
    logic                    push;
    logic                    pop;
    logic [DATA_WIDTH-1:0]   push_data;
    logic [DATA_WIDTH-1:0]   push_pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        push_fetch = 1'b0;
        push_err   = 1'b0;
        misalign   = 1'b0;
        pc_ready_o = (state_q == ST_IDLE) && (count_q < FULL_CNT) && !flush_i;
        accept     = pc_valid_i && pc_ready_o;
        // A response in the same cycle as the request pulse cannot be ours.
        rvalid_eff = mem_rvalid_i && !mem_req_o;
`ifdef FETCH_MISALIGN_CHECK_EN
        misalign   = (pc_i[1:0] != 2'b00);
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (misalign) begin
                        push_err = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (flush_i) begin
                    state_d = rvalid_eff ? ST_IDLE : ST_DROP;
                end else if (rvalid_eff) begin
                    state_d    = ST_IDLE;
                    push_fetch = 1'b1;
                end
            end
            ST_DROP: begin
                if (rvalid_eff) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req_o  <= 1'b0;
            mem_addr_o <= '0;
            pc_q       <= '0;
        end else begin
            mem_req_o <= accept && !misalign;
            if (accept && !misalign) begin
                mem_addr_o <= {pc_i[DATA_WIDTH-1:2], 2'b00};
                pc_q       <= pc_i;
            end
        end
    end

    assign push      = push_fetch || push_err;
    assign push_data = push_fetch ? mem_rdata_i : '0;
    assign push_pc   = push_fetch ? pc_q : pc_i;
    assign pop       = instr_valid_o && instr_ready_i;

    // Flush wins over push and pop in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_pc[i]   <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
                fifo_err[i]  <= 1'b0;
`endif
            end
        end else if (flush_i) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= push_data;
                fifo_pc[wr_ptr]   <= push_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
                fifo_err[wr_ptr]  <= push_err;
`endif
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign instr_valid_o = (count_q != '0);
    assign instr_o       = fifo_data[rd_ptr];
    assign instr_pc_o    = fifo_pc[rd_ptr];
`ifdef FETCH_MISALIGN_CHECK_EN
    assign instr_err_o   = fifo_err[rd_ptr];
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit (default or misalign-check build).
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc = '0;
    logic        pc_valid = 1'b0;
    logic        pc_ready;
    logic        flush = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        instr_err;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.DATA_WIDTH(32), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .pc_i(pc), .pc_valid_i(pc_valid), .pc_ready_o(pc_ready),
        .flush_i(flush), .mem_req_o(mem_req), .mem_addr_o(mem_addr),
        .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
        .instr_valid_o(instr_valid), .instr_ready_i(instr_ready),
        .instr_o(instr), .instr_pc_o(instr_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
        , .instr_err_o(instr_err)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stimulus only: accept one PC and return data with latency 1.
    task automatic fetch(input logic [31:0] a, input logic [31:0] d);
        pc_valid = 1'b1; pc = a;
        tick();
        pc_valid = 1'b0;
        tick();
        mem_rvalid = 1'b1; mem_rdata = d;
        tick();
        mem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(); tick();
        rst = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %h exp 0", mem_addr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid got %b exp 0", instr_valid); end
        checks++; if (instr !== 32'h0 || instr_pc !== 32'h0) begin errors++; $display("FAIL reset_head got %h/%h exp 0/0", instr, instr_pc); end
        checks++; if (pc_ready !== 1'b1) begin errors++; $display("FAIL reset_pc_ready got %b exp 1", pc_ready); end
    endtask

    task automatic test_basic();
        pc_valid = 1'b1; pc = 32'h0;
        tick();
        pc_valid = 1'b0;
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL basic_req_t1 got %b exp 1", mem_req); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL basic_addr got %h exp 0", mem_addr); end
        checks++; if (dut.state_q !== 2'd1) begin errors++; $display("FAIL basic_state_wait got %0d exp 1", dut.state_q); end
        checks++; if (pc_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_wait got %b exp 0", pc_ready); end
        tick();
        mem_rvalid = 1'b1; mem_rdata = 32'h0050_0093;
        checks++; if (mem_req !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL basic_t2 got req %b valid %b exp 0 0", mem_req, instr_valid); end
        tick();
        mem_rvalid = 1'b0;
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL basic_valid_t3 got %b exp 1", instr_valid); end
        checks++; if (instr !== 32'h0050_0093) begin errors++; $display("FAIL basic_instr got %h exp 00500093", instr); end
        checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL basic_instr_pc got %h exp 0", instr_pc); end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL basic_pop got %b exp 0", instr_valid); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) fetch(32'(i * 4), 32'h100 + 32'(i));
        checks++; if (dut.count_q !== 3'd4) begin errors++; $display("FAIL full_count got %0d exp 4", dut.count_q); end
        checks++; if (pc_ready !== 1'b0) begin errors++; $display("FAIL full_pc_ready got %b exp 0", pc_ready); end
        pc_valid = 1'b1; pc = 32'h10;
        tick();
        pc_valid = 1'b0;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL full_no_req got %b exp 0", mem_req); end
        checks++; if (instr !== 32'h100 || instr_pc !== 32'h0) begin errors++; $display("FAIL full_head0 got %h/%h exp 100/0", instr, instr_pc); end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        checks++; if (pc_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after_pop got %b exp 1", pc_ready); end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (instr_pc !== 32'(i * 4) || instr !== 32'h100 + 32'(i))
                begin errors++; $display("FAIL full_order%0d got %h/%h exp %h/%h", i, instr, instr_pc, 32'h100 + 32'(i), 32'(i * 4)); end
            instr_ready = 1'b1;
            tick();
            instr_ready = 1'b0;
        end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL full_drained got %b exp 0", instr_valid); end
    endtask

    task automatic test_flush_wait();
        pc_valid = 1'b1; pc = 32'h20;
        tick();
        pc_valid = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (dut.state_q !== 2'd2) begin errors++; $display("FAIL flushw_drop got %0d exp 2", dut.state_q); end
        checks++; if (pc_ready !== 1'b0) begin errors++; $display("FAIL flushw_ready_drop got %b exp 0", pc_ready); end
        tick();
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_rvalid = 1'b0;
        checks++; if (dut.state_q !== 2'd0) begin errors++; $display("FAIL flushw_idle got %0d exp 0", dut.state_q); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL flushw_nopush got %b exp 0", instr_valid); end
        checks++; if (pc_ready !== 1'b1) begin errors++; $display("FAIL flushw_ready got %b exp 1", pc_ready); end
        tick();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL flushw_stay got %b exp 0", instr_valid); end
    endtask

    task automatic test_flush_rvalid();
        fetch(32'h40, 32'h11);
        fetch(32'h44, 32'h22);
        checks++; if (dut.count_q !== 3'd2) begin errors++; $display("FAIL flushr_pre got %0d exp 2", dut.count_q); end
        pc_valid = 1'b1; pc = 32'h48;
        tick();
        pc_valid = 1'b0;
        tick();
        mem_rvalid = 1'b1; mem_rdata = 32'h33; flush = 1'b1;
        tick();
        mem_rvalid = 1'b0; flush = 1'b0;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL flushr_empty got %b exp 0", instr_valid); end
        checks++; if (dut.state_q !== 2'd0) begin errors++; $display("FAIL flushr_idle got %0d exp 0", dut.state_q); end
        checks++; if (dut.count_q !== 3'd0) begin errors++; $display("FAIL flushr_count got %0d exp 0", dut.count_q); end
        tick();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL flushr_dropped got %b exp 0", instr_valid); end
    endtask

    task automatic test_back_to_back();
        fetch(32'h60, 32'hA0);
        fetch(32'h64, 32'hA1);
        pc_valid = 1'b1; pc = 32'h68;
        tick();
        pc_valid = 1'b0;
        tick();
        mem_rvalid = 1'b1; mem_rdata = 32'hA2; instr_ready = 1'b1;
        checks++; if (instr_pc !== 32'h60) begin errors++; $display("FAIL b2b_head_before got %h exp 60", instr_pc); end
        tick();
        mem_rvalid = 1'b0; instr_ready = 1'b0;
        checks++; if (dut.count_q !== 3'd2) begin errors++; $display("FAIL b2b_count got %0d exp 2", dut.count_q); end
        checks++; if (instr_pc !== 32'h64 || instr !== 32'hA1) begin errors++; $display("FAIL b2b_head_after got %h/%h exp A1/64", instr, instr_pc); end
        instr_ready = 1'b1;
        tick(); tick();
        instr_ready = 1'b0;
        fetch(32'h6C, 32'hA3);
        fetch(32'h70, 32'hA4);
        checks++; if (dut.wr_ptr !== 2'd1) begin errors++; $display("FAIL b2b_wrap_ptr got %0d exp 1", dut.wr_ptr); end
        checks++; if (instr_pc !== 32'h6C || instr !== 32'hA3) begin errors++; $display("FAIL b2b_wrap_head got %h/%h exp A3/6C", instr, instr_pc); end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        checks++; if (instr_pc !== 32'h70 || instr !== 32'hA4) begin errors++; $display("FAIL b2b_wrap_next got %h/%h exp A4/70", instr, instr_pc); end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
    endtask

    task automatic test_misalign();
        pc_valid = 1'b1; pc = 32'h102;
        tick();
        pc_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL mis_no_req got %b exp 0", mem_req); end
        checks++; if (instr_valid !== 1'b1 || instr !== 32'h0 || instr_pc !== 32'h102) begin errors++; $display("FAIL mis_entry got %b %h/%h exp 1 0/102", instr_valid, instr, instr_pc); end
        checks++; if (instr_err !== 1'b1) begin errors++; $display("FAIL mis_err got %b exp 1", instr_err); end
        checks++; if (dut.state_q !== 2'd0) begin errors++; $display("FAIL mis_idle got %0d exp 0", dut.state_q); end
`else
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin errors++; $display("FAIL mis_addr got %b %h exp 1 100", mem_req, mem_addr); end
        tick();
        mem_rvalid = 1'b1; mem_rdata = 32'h55;
        tick();
        mem_rvalid = 1'b0;
        checks++; if (instr_pc !== 32'h102 || instr !== 32'h55) begin errors++; $display("FAIL mis_entry got %h/%h exp 55/102", instr, instr_pc); end
`endif
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        pc_valid = 1'b1; pc = 32'h80;
        tick();
        pc_valid = 1'b0;
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rstmid_req got %b exp 1", mem_req); end
        rst = 1'b0;
        #1;
        checks++; if (dut.state_q !== 2'd0 || mem_req !== 1'b0 || mem_addr !== 32'h0) begin errors++; $display("FAIL rstmid_clear got %0d %b %h exp 0 0 0", dut.state_q, mem_req, mem_addr); end
        tick();
        rst = 1'b1;
        #1;
        checks++; if (pc_ready !== 1'b1 || instr_valid !== 1'b0) begin errors++; $display("FAIL rstmid_after got %b %b exp 1 0", pc_ready, instr_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_flush_wait();
        test_flush_rvalid();
        test_back_to_back();
        test_misalign();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
